lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// Purpose: LC-3 style single-port 16-bit word memory controller with an IDLE/WAIT/DONE handshake FSM.
// Latency: complete pulses WAIT_CYCLES+1 cycles after the accepting edge; read data is valid in that same cycle.
// Backpressure: while busy, new requests are dropped, not queued; optional bounds checking under LC3_MEM_BOUNDS_CHECK_EN.
module lc3_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        complete,
  output logic        busy
`ifdef LC3_MEM_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] cap_addr;
  logic [15:0] cap_din;
  logic        cap_wr;
  logic [15:0] dout_q;
  logic        err_q;

  // Zero at time zero; reset deliberately leaves the contents alone.
  logic [15:0] mem [0:DEPTH-1] = '{default: 16'h0000};

  logic        accept;
  logic [15:0] op_addr;
  logic        op_wr;
  logic        op_oor;
  logic        cap_oor;

  // Request seen this cycle in IDLE; read wins when rd and we collide.
  assign accept  = (state == IDLE) && (rd || we);
  assign op_addr = (state == IDLE) ? addr : cap_addr;
  assign op_wr   = (state == IDLE) ? (we & ~rd) : cap_wr;

`ifdef LC3_MEM_BOUNDS_CHECK_EN
  // Any address bit above the memory width marks the access out of range.
  assign op_oor  = |(op_addr >> ADDR_W);
  assign cap_oor = |(cap_addr >> ADDR_W);
`else
  // Without bounds checking the upper address bits are dropped and accesses wrap.
  logic unused_addr_hi;
  assign op_oor         = 1'b0;
  assign cap_oor        = 1'b0;
  assign unused_addr_hi = ^{op_addr, cap_addr};
`endif

  // State and wait counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE accepts, WAIT counts down, DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request, and load read data / error flag as DONE is entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cap_addr <= 16'h0000;
      cap_din  <= 16'h0000;
      cap_wr   <= 1'b0;
      dout_q   <= 16'h0000;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr <= addr;
        cap_din  <= din;
        cap_wr   <= we & ~rd;
      end
      if (state_nxt == DONE) begin
        err_q <= op_oor;
        if (!op_wr) dout_q <= op_oor ? 16'h0000 : mem[op_addr[ADDR_W-1:0]];
      end else if (accept) begin
        err_q <= 1'b0;
      end
    end
  end

  // Writes commit at the edge closing DONE, and only if reset does not abort it.
  always_ff @(posedge clock) begin
    if (reset && (state == DONE) && cap_wr && !cap_oor) begin
      mem[cap_addr[ADDR_W-1:0]] <= cap_din;
    end
  end

  // Outputs are forced quiet while reset is held, including mid-access.
  assign dout     = reset ? dout_q : 16'h0000;
  assign complete = reset && (state == DONE);
  assign busy     = reset && (state != IDLE);
`ifdef LC3_MEM_BOUNDS_CHECK_EN
  assign err      = reset && err_q;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Purpose: self-checking bench for lc3_mem_ctrl (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Latency: expects complete WAIT_CYCLES+1 cycles after each accepting edge.
// Backpressure: drives random junk requests while busy and expects them to be dropped.
module tb_lc3_mem_ctrl;

  localparam int WA = 2;
`ifdef LC3_MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clock, reset;
  logic        rd_a, we_a, rd_b, we_b;
  logic [15:0] addr_a, din_a, addr_b, din_b;
  logic [15:0] dout_a, dout_b;
  logic        complete_a, busy_a, complete_b, busy_b;
`ifdef LC3_MEM_BOUNDS_CHECK_EN
  logic        err_a, err_b;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] mdl_a [256];
  logic [15:0] mdl_b [256];
  logic [15:0] last_rd_a, last_rd_b;

  lc3_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(WA)) u_a (
    .clock(clock), .reset(reset), .rd(rd_a), .we(we_a), .addr(addr_a), .din(din_a),
    .dout(dout_a), .complete(complete_a), .busy(busy_a)
`ifdef LC3_MEM_BOUNDS_CHECK_EN
    , .err(err_a)
`endif
  );

  lc3_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_b (
    .clock(clock), .reset(reset), .rd(rd_b), .we(we_b), .addr(addr_b), .din(din_b),
    .dout(dout_b), .complete(complete_b), .busy(busy_b)
`ifdef LC3_MEM_BOUNDS_CHECK_EN
    , .err(err_b)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One access on instance A, with junk requests driven throughout the busy window.
  task automatic access_a(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input string nm);
    logic        oor;
    logic [15:0] exp_rd;
    logic [15:0] exp_dout;
    logic        exp_c;
    oor      = BC && (a[15:8] != 8'h00);
    exp_rd   = oor ? 16'h0000 : mdl_a[a[7:0]];
    exp_dout = r ? exp_rd : last_rd_a;
    rd_a = r; we_a = w; addr_a = a; din_a = d;
    cyc();
    for (int k = 1; k <= WA + 1; k++) begin
      exp_c = (k == WA + 1);
      checks++;
      if (busy_a !== 1'b1) begin
        failures++;
        $display("FAIL %s busy k=%0d got=%b exp=1", nm, k, busy_a);
      end
      checks++;
      if (complete_a !== exp_c) begin
        failures++;
        $display("FAIL %s complete k=%0d got=%b exp=%b", nm, k, complete_a, exp_c);
      end
      if (exp_c) begin
        checks++;
        if (dout_a !== exp_dout) begin
          failures++;
          $display("FAIL %s dout got=%h exp=%h", nm, dout_a, exp_dout);
        end
`ifdef LC3_MEM_BOUNDS_CHECK_EN
        checks++;
        if (err_a !== oor) begin
          failures++;
          $display("FAIL %s err got=%b exp=%b", nm, err_a, oor);
        end
`endif
      end
      rd_a = 1'($urandom); we_a = 1'($urandom);
      addr_a = 16'($urandom); din_a = 16'($urandom);
      cyc();
    end
    rd_a = 1'b0; we_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || complete_a !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after busy=%b complete=%b exp=0/0", nm, busy_a, complete_a);
    end
    checks++;
    if (dout_a !== exp_dout) begin
      failures++;
      $display("FAIL %s dout_hold got=%h exp=%h", nm, dout_a, exp_dout);
    end
`ifdef LC3_MEM_BOUNDS_CHECK_EN
    checks++;
    if (err_a !== oor) begin
      failures++;
      $display("FAIL %s err_hold got=%b exp=%b", nm, err_a, oor);
    end
`endif
    if (r) last_rd_a = exp_rd;
    else if (w && !oor) mdl_a[a[7:0]] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rd_b = 1'b0; we_b = 1'b0; addr_b = 16'h0; din_b = 16'h0;
    for (int i = 0; i < 4; i++) begin
      rd_a = 1'($urandom); we_a = 1'($urandom);
      addr_a = 16'($urandom); din_a = 16'($urandom);
      rd_b = 1'($urandom); we_b = 1'($urandom);
      addr_b = 16'($urandom); din_b = 16'($urandom);
      cyc();
      checks++;
      if (busy_a !== 1'b0 || complete_a !== 1'b0 || dout_a !== 16'h0000) begin
        failures++;
        $display("FAIL reset_a busy=%b complete=%b dout=%h exp=0/0/0000", busy_a, complete_a, dout_a);
      end
      checks++;
      if (busy_b !== 1'b0 || complete_b !== 1'b0 || dout_b !== 16'h0000) begin
        failures++;
        $display("FAIL reset_b busy=%b complete=%b dout=%h exp=0/0/0000", busy_b, complete_b, dout_b);
      end
    end
    rd_b = 1'b0; we_b = 1'b0;
    reset = 1'b1;
    last_rd_a = 16'h0000;
    last_rd_b = 16'h0000;
    // First edge with reset high must accept; fresh memory reads as zero.
    access_a(1'b1, 1'b0, 16'h0007, 16'h0000, "first_after_reset");
  endtask

  task automatic test_write_read();
    access_a(1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr_beef");
    access_a(1'b1, 1'b0, 16'h0010, 16'h0000, "rd_beef");
    access_a(1'b1, 1'b0, 16'h00F0, 16'h0000, "rd_unwritten");
  endtask

  task automatic test_rd_we_priority();
    access_a(1'b0, 1'b1, 16'h0005, 16'h1234, "wr_1234");
    access_a(1'b1, 1'b1, 16'h0005, 16'hFFFF, "rdwe_both");
    access_a(1'b1, 1'b0, 16'h0005, 16'h0000, "rd_after_both");
  endtask

  task automatic test_reset_abort();
    access_a(1'b0, 1'b1, 16'h0020, 16'h1111, "wr_1111");
    // Abort in WAIT.
    rd_a = 1'b0; we_a = 1'b1; addr_a = 16'h0020; din_a = 16'h2222;
    cyc();
    we_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_wait accepted busy=%b exp=1", busy_a);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_a !== 1'b0 || complete_a !== 1'b0 || dout_a !== 16'h0000) begin
        failures++;
        $display("FAIL abort_wait i=%0d busy=%b complete=%b dout=%h exp=0/0/0000", i, busy_a, complete_a, dout_a);
      end
      cyc();
    end
    reset = 1'b1;
    last_rd_a = 16'h0000;
    last_rd_b = 16'h0000;
    access_a(1'b1, 1'b0, 16'h0020, 16'h0000, "rd_after_abort_wait");
    // Abort in DONE.
    rd_a = 1'b0; we_a = 1'b1; addr_a = 16'h0020; din_a = 16'h3333;
    cyc();
    we_a = 1'b0;
    for (int i = 0; i < WA; i++) cyc();
    checks++;
    if (complete_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_done reached complete=%b exp=1", complete_a);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (complete_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_done gated complete=%b busy=%b exp=0/0", complete_a, busy_a);
    end
    cyc();
    reset = 1'b1;
    last_rd_a = 16'h0000;
    last_rd_b = 16'h0000;
    access_a(1'b1, 1'b0, 16'h0020, 16'h0000, "rd_after_abort_done");
  endtask

  task automatic test_wrap();
    access_a(1'b0, 1'b1, 16'h0003, 16'h0C0C, "wr_0003");
    access_a(1'b0, 1'b1, 16'h0103, 16'hA5A5, "wr_0103");
    access_a(1'b1, 1'b0, 16'h0003, 16'h0000, "rd_0003");
    access_a(1'b1, 1'b0, 16'h0103, 16'h0000, "rd_0103");
  endtask

  task automatic test_random();
    logic        r, w;
    logic [15:0] a;
    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom);
      w = ~r | 1'($urandom);
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom_range(1, 255));
      access_a(r, w, a, 16'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic        op_r [6];
    logic [15:0] op_a [6];
    logic [15:0] op_d [6];
    logic [15:0] exp_d;
    op_r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    op_a = '{16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0002, 16'h0001};
    for (int i = 0; i < 6; i++) op_d[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) begin
      rd_b = op_r[i]; we_b = ~op_r[i]; addr_b = op_a[i]; din_b = op_d[i];
      exp_d = op_r[i] ? mdl_b[op_a[i][7:0]] : last_rd_b;
      cyc();
      rd_b = 1'b0; we_b = 1'b0;
      checks++;
      if (complete_b !== 1'b1 || busy_b !== 1'b1) begin
        failures++;
        $display("FAIL b2b op=%0d complete=%b busy=%b exp=1/1", i, complete_b, busy_b);
      end
      checks++;
      if (dout_b !== exp_d) begin
        failures++;
        $display("FAIL b2b op=%0d dout got=%h exp=%h", i, dout_b, exp_d);
      end
      if (op_r[i]) last_rd_b = exp_d;
      else mdl_b[op_a[i][7:0]] = op_d[i];
      cyc();
      checks++;
      if (complete_b !== 1'b0 || busy_b !== 1'b0) begin
        failures++;
        $display("FAIL b2b_gap op=%0d complete=%b busy=%b exp=0/0", i, complete_b, busy_b);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl_a[i] = 16'h0000;
      mdl_b[i] = 16'h0000;
    end
    rd_a = 1'b0; we_a = 1'b0; addr_a = 16'h0; din_a = 16'h0;
    rd_b = 1'b0; we_b = 1'b0; addr_b = 16'h0; din_b = 16'h0;
    last_rd_a = 16'h0000;
    last_rd_b = 16'h0000;
    reset = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_rd_we_priority();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
